clock_set_ctrl: RTL

- Time-set controller for the BCD HH:MM clock datapath.
- Sequences RUN / SET_HRS / SET_MIN modes from debounced Mode and Inc button pulses, and edits a shadow copy of the time.
- Holds the seconds counter during setting, commits the edited time to the datapath in one load strobe, and drives per-digit blink blanking to the seven-segment driver.

---
 rtl/clock_pkg.sv | 38 +++
 rtl/bcd2_inc.sv | 31 +++
 rtl/clock_set_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared mode encoding, digit indices and BCD limits for the
//             HH:MM clock time-set path.
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HRS = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN     = MODE_RUN,
        ST_SET_HRS = MODE_SET_HRS,
        ST_SET_MIN = MODE_SET_MIN
    } mode_e;

    localparam int DIG_HRS_TENS  = 3;
    localparam int DIG_HRS_UNITS = 2;
    localparam int DIG_MIN_TENS  = 1;
    localparam int DIG_MIN_UNITS = 0;

    localparam int HRS_MAX = 23;
    localparam int MIN_MAX = 59;

    // True when both digits are decimal and the two-digit value fits the limit.
    function automatic logic bcd2_valid(input logic [3:0] tens,
                                        input logic [3:0] units,
                                        input int         max_val);
        return (tens <= 4'd9) && (units <= 4'd9) &&
               ((int'(tens) * 10 + int'(units)) <= max_val);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2_inc.sv
// ============================================================================
// bcd2_inc : two-digit BCD incrementer; wraps to 00 when the input equals the
//            supplied maximum value.
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module bcd2_inc (
    input  logic [3:0] tens_i,
    input  logic [3:0] units_i,
    input  logic [3:0] max_tens_i,
    input  logic [3:0] max_units_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    always_comb begin
        tens_o  = tens_i;
        units_o = units_i + 4'd1;
        if ((tens_i == max_tens_i) && (units_i == max_units_i)) begin
            tens_o  = 4'd0;
            units_o = 4'd0;
        end else if (units_i >= 4'd9) begin
            tens_o  = tens_i + 4'd1;
            units_o = 4'd0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_set_ctrl.sv
// ============================================================================
// clock_set_ctrl : RUN/SET_HRS/SET_MIN time-set controller with shadow time,
//                  commit strobe and digit blink. Option: CLK_SET_TIMEOUT_EN.
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_CYCLES   = 50_000_000,
    parameter int TIMEOUT_HALVES = 20
) (
    input  logic       Clk_100M,
    input  logic       Reset_n,
    input  logic       Mode_Pulse,
    input  logic       Inc_Pulse,
    input  logic [3:0] Hours_Tens_In,
    input  logic [3:0] Hours_Units_In,
    input  logic [3:0] Minutes_Tens_In,
    input  logic [3:0] Minutes_Units_In,
    output logic [3:0] Hours_Tens_Out,
    output logic [3:0] Hours_Units_Out,
    output logic [3:0] Minutes_Tens_Out,
    output logic [3:0] Minutes_Units_Out,
    output logic       Load_Time,
    output logic       Clear_Seconds,
    output logic       Count_En,
    output logic [3:0] Digit_Blank,
    output logic [1:0] Mode
);

    localparam int PRESC_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_CYCLES - 1);

    if ((BLINK_CYCLES < 1) || (TIMEOUT_HALVES < 1)) begin : g_param_check
        $error("clock_set_ctrl: BLINK_CYCLES and TIMEOUT_HALVES must be >= 1");
    end

    mode_e              state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               phase_q, phase_d;
    logic [3:0]         ht_q, ht_d, hu_q, hu_d, mt_q, mt_d, mu_q, mu_d;
    logic               load_q, load_d;
    logic               count_en_q, count_en_d;
    logic [3:0]         blank_q, blank_d;

    logic [3:0] hrs_inc_t, hrs_inc_u, min_inc_t, min_inc_u;
    logic       in_set, wrap, timeout;

    bcd2_inc u_hrs_inc (
        .tens_i      (ht_q),
        .units_i     (hu_q),
        .max_tens_i  (4'(HRS_MAX / 10)),
        .max_units_i (4'(HRS_MAX % 10)),
        .tens_o      (hrs_inc_t),
        .units_o     (hrs_inc_u)
    );

    bcd2_inc u_min_inc (
        .tens_i      (mt_q),
        .units_i     (mu_q),
        .max_tens_i  (4'(MIN_MAX / 10)),
        .max_units_i (4'(MIN_MAX % 10)),
        .tens_o      (min_inc_t),
        .units_o     (min_inc_u)
    );

    assign in_set = (state_q == ST_SET_HRS) || (state_q == ST_SET_MIN);
    assign wrap   = in_set && (presc_q == PRESC_LAST);

`ifdef CLK_SET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_HALVES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;

    // Any button activity counts as "not idle", so it also suppresses the timeout.
    assign timeout = wrap && !Mode_Pulse && !Inc_Pulse &&
                     (idle_q == IDLE_W'(TIMEOUT_HALVES - 1));

    always_comb begin
        idle_d = idle_q;
        if (!in_set || Mode_Pulse || Inc_Pulse) begin
            idle_d = '0;
        end else if (wrap) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        ht_d    = ht_q;
        hu_d    = hu_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        case (state_q)
            ST_RUN: begin
                if (Mode_Pulse) begin
                    state_d = ST_SET_HRS;
                    if (bcd2_valid(Hours_Tens_In, Hours_Units_In, HRS_MAX)) begin
                        ht_d = Hours_Tens_In;
                        hu_d = Hours_Units_In;
                    end else begin
                        ht_d = 4'd0;
                        hu_d = 4'd0;
                    end
                    if (bcd2_valid(Minutes_Tens_In, Minutes_Units_In, MIN_MAX)) begin
                        mt_d = Minutes_Tens_In;
                        mu_d = Minutes_Units_In;
                    end else begin
                        mt_d = 4'd0;
                        mu_d = 4'd0;
                    end
                end
            end
            ST_SET_HRS: begin
                if (Mode_Pulse) begin
                    state_d = ST_SET_MIN;
                end else if (timeout) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (Inc_Pulse) begin
                    ht_d = hrs_inc_t;
                    hu_d = hrs_inc_u;
                end
            end
            ST_SET_MIN: begin
                if (Mode_Pulse || timeout) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end else if (Inc_Pulse) begin
                    mt_d = min_inc_t;
                    mu_d = min_inc_u;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Restart the blink on every edit or mode change so the digits show at once.
    always_comb begin
        presc_d = presc_q + 1'b1;
        phase_d = phase_q;
        if (!in_set || (state_d != state_q) || Inc_Pulse) begin
            presc_d = '0;
            phase_d = 1'b0;
        end else if (wrap) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        count_en_d = (state_d == ST_RUN);
        blank_d    = 4'b0000;
        case (state_d)
            ST_SET_HRS: begin
                blank_d[DIG_HRS_TENS]  = phase_d;
                blank_d[DIG_HRS_UNITS] = phase_d;
            end
            ST_SET_MIN: begin
                blank_d[DIG_MIN_TENS]  = phase_d;
                blank_d[DIG_MIN_UNITS] = phase_d;
            end
            default: blank_d = 4'b0000;
        endcase
    end

    always_ff @(posedge Clk_100M or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_RUN;
            presc_q    <= '0;
            phase_q    <= 1'b0;
            ht_q       <= 4'd0;
            hu_q       <= 4'd0;
            mt_q       <= 4'd0;
            mu_q       <= 4'd0;
            load_q     <= 1'b0;
            count_en_q <= 1'b1;
            blank_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            ht_q       <= ht_d;
            hu_q       <= hu_d;
            mt_q       <= mt_d;
            mu_q       <= mu_d;
            load_q     <= load_d;
            count_en_q <= count_en_d;
            blank_q    <= blank_d;
        end
    end

    assign Mode              = state_q;
    assign Count_En          = count_en_q;
    assign Load_Time         = load_q;
    assign Clear_Seconds     = load_q;
    assign Digit_Blank       = blank_q;
    assign Hours_Tens_Out    = ht_q;
    assign Hours_Units_Out   = hu_q;
    assign Minutes_Tens_Out  = mt_q;
    assign Minutes_Units_Out = mu_q;

endmodule

`default_nettype wire
